// File: rtl/cond_logic_seq.sv
// rtl/cond_logic_seq.sv - ARM condition evaluation, NZCV flag banks, write-strobe gating and saved-flags stack
module cond_logic_seq #(
    parameter int NUM_BANKS  = 2,
    parameter int SAVE_DEPTH = 4,
    parameter int NV_MODE    = 0,
    parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int CNT_W     = $clog2(SAVE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cond_valid,
    input  logic [3:0]        cond,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic [3:0]        alu_flags,
    input  logic [1:0]        flag_w,
    input  logic              next_pc,
    input  logic              pcs,
    input  logic              reg_w,
    input  logic              mem_w,
    input  logic              push,
    input  logic              pop,
    output logic              pc_write,
    output logic              reg_write,
    output logic              mem_write,
    output logic              cond_ex,
    output logic [3:0]        flags,
    output logic [CNT_W-1:0]  stack_cnt,
    output logic              stack_err
);
    localparam int IDX_W = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;

    logic [3:0]       banks [NUM_BANKS];
    logic [3:0]       stack [SAVE_DEPTH];
    logic             bank_ok;
    logic [3:0]       cur_flags;
    logic             cond_res;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             err_set;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;

    // Out-of-range bank selects read as all-zero flags and swallow writes.
    assign bank_ok   = ({1'b0, bank_sel} < (BANK_W + 1)'(NUM_BANKS));
    assign cur_flags = bank_ok ? banks[bank_sel] : 4'b0000;

    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, ge;
        {n, z, cf, v} = f;
        ge = (n == v);
        case (c)
            4'b0000: eval_cond = z;
            4'b0001: eval_cond = ~z;
            4'b0010: eval_cond = cf;
            4'b0011: eval_cond = ~cf;
            4'b0100: eval_cond = n;
            4'b0101: eval_cond = ~n;
            4'b0110: eval_cond = v;
            4'b0111: eval_cond = ~v;
            4'b1000: eval_cond = cf & ~z;
            4'b1001: eval_cond = ~(cf & ~z);
            4'b1010: eval_cond = ge;
            4'b1011: eval_cond = ~ge;
            4'b1100: eval_cond = ~z & ge;
            4'b1101: eval_cond = ~(~z & ge);
            4'b1110: eval_cond = 1'b1;
            default: eval_cond = (NV_MODE != 0);
        endcase
    endfunction

    assign cond_res = eval_cond(cond, cur_flags);

    assign full     = (stack_cnt == CNT_W'(SAVE_DEPTH));
    assign empty    = (stack_cnt == '0);
    assign do_push  = push & ~pop & ~full;
    assign do_pop   = pop & ~push & ~empty;
    assign err_set  = (push & pop) | (push & full) | (pop & empty);
    assign push_idx = IDX_W'(stack_cnt);
    assign top_idx  = IDX_W'(stack_cnt - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_ex   <= 1'b0;
            stack_cnt <= '0;
            stack_err <= 1'b0;
        end else begin
            if (cond_valid) cond_ex <= cond_res;
            if (do_push) stack_cnt <= stack_cnt + 1'b1;
            else if (do_pop) stack_cnt <= stack_cnt - 1'b1;
            if (err_set) stack_err <= 1'b1;
        end
    end

    // A pop restore takes priority over a gated ALU flag update to the same bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) banks[b] <= 4'b0000;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_ok && bank_sel == BANK_W'(b)) begin
                    if (do_pop) begin
                        banks[b] <= stack[top_idx];
                    end else if (cond_ex) begin
                        if (flag_w[1]) banks[b][3:2] <= alu_flags[3:2];
                        if (flag_w[0]) banks[b][1:0] <= alu_flags[1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) stack[push_idx] <= cur_flags;
    end

    assign flags     = cur_flags;
    assign pc_write  = next_pc | (pcs & cond_ex);
    assign reg_write = reg_w & cond_ex;
    assign mem_write = mem_w & cond_ex;
endmodule

// File: tb/tb_cond_logic_seq.sv
// tb/tb_cond_logic_seq.sv - directed scoreboard bench for cond_logic_seq
module tb_cond_logic_seq;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       cond_valid;
    logic [3:0] cond;
    logic [0:0] bank_sel;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       next_pc, pcs, reg_w, mem_w, push, pop;
    logic       pc_write, reg_write, mem_write, cond_ex, stack_err;
    logic [3:0] flags;
    logic [2:0] stack_cnt;

    int total = 0;
    int bad   = 0;

    localparam int S_CEX = 0, S_FLG = 1, S_CNT = 2, S_ERR = 3, S_PCW = 4, S_REGW = 5, S_MEMW = 6;

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    logic [3:0] vals [4];

    cond_logic_seq dut (
        .clk(clk), .reset_n(reset_n), .cond_valid(cond_valid), .cond(cond),
        .bank_sel(bank_sel), .alu_flags(alu_flags), .flag_w(flag_w),
        .next_pc(next_pc), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
        .push(push), .pop(pop), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .cond_ex(cond_ex), .flags(flags),
        .stack_cnt(stack_cnt), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] observe(input int sel);
        case (sel)
            S_CEX:   observe = {3'b0, cond_ex};
            S_FLG:   observe = flags;
            S_CNT:   observe = {1'b0, stack_cnt};
            S_ERR:   observe = {3'b0, stack_err};
            S_PCW:   observe = {3'b0, pc_write};
            S_REGW:  observe = {3'b0, reg_write};
            default: observe = {3'b0, mem_write};
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [3:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [3:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cond_valid = 0; cond = 4'h0; flag_w = 2'b00; alu_flags = 4'h0;
        next_pc = 0; pcs = 0; reg_w = 0; mem_w = 0; push = 0; pop = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        @(negedge clk);
        reset_n = 1;
        #1;
    endtask

    initial begin
        vals[0] = 4'h3; vals[1] = 4'h5; vals[2] = 4'h9; vals[3] = 4'hC;
        reset_n = 0; bank_sel = 1'b0;
        idle();
        #1;
        next_pc = 1; reg_w = 1; mem_w = 1; pcs = 1;
        #1;
        expect_val("rst_cond_ex", S_CEX, 4'h0);
        expect_val("rst_flags", S_FLG, 4'h0);
        expect_val("rst_cnt", S_CNT, 4'h0);
        expect_val("rst_err", S_ERR, 4'h0);
        expect_val("rst_pc_write", S_PCW, 4'h1);
        expect_val("rst_reg_write", S_REGW, 4'h0);
        expect_val("rst_mem_write", S_MEMW, 4'h0);
        check_out();
        idle();
        @(negedge clk);
        reset_n = 1;

        // AL condition enables writes one cycle after decode
        cond_valid = 1; cond = 4'hE;
        tick();
        idle();
        reg_w = 1; pcs = 1;
        #1;
        expect_val("al_cond_ex", S_CEX, 4'h1);
        expect_val("al_reg_write", S_REGW, 4'h1);
        expect_val("al_pc_write", S_PCW, 4'h1);
        check_out();
        idle();

        flag_w = 2'b11; alu_flags = 4'h4;
        tick();
        idle();
        expect_val("set_z_flags", S_FLG, 4'h4);
        check_out();

        cond_valid = 1; cond = 4'h0;
        tick();
        expect_val("eq_cond_ex", S_CEX, 4'h1);
        check_out();
        cond = 4'h1;
        tick();
        idle();
        mem_w = 1; pcs = 1;
        #1;
        expect_val("ne_cond_ex", S_CEX, 4'h0);
        expect_val("ne_mem_write", S_MEMW, 4'h0);
        expect_val("ne_pc_write", S_PCW, 4'h0);
        check_out();
        idle();

        // flag writes blocked while cond_ex=0
        flag_w = 2'b11; alu_flags = 4'hF;
        tick();
        idle();
        expect_val("gated_flags_hold", S_FLG, 4'h4);
        check_out();
        cond_valid = 1; cond = 4'hE;
        tick();
        idle();
        flag_w = 2'b11; alu_flags = 4'hF;
        tick();
        idle();
        expect_val("flags_written", S_FLG, 4'hF);
        check_out();

        // decode alongside a flag write sees pre-write flags
        cond_valid = 1; cond = 4'h0; flag_w = 2'b11; alu_flags = 4'h0;
        tick();
        idle();
        expect_val("same_cycle_cond_ex", S_CEX, 4'h1);
        expect_val("same_cycle_flags", S_FLG, 4'h0);
        check_out();

        // bank1 N=1 V=0
        bank_sel = 1'b1; flag_w = 2'b11; alu_flags = 4'h8;
        tick();
        idle();
        expect_val("bank1_flags", S_FLG, 4'h8);
        check_out();
        bank_sel = 1'b0;
        #1;
        expect_val("bank0_untouched", S_FLG, 4'h0);
        check_out();
        bank_sel = 1'b1;
        cond_valid = 1; cond = 4'hB;
        tick();
        expect_val("lt_cond_ex", S_CEX, 4'h1);
        check_out();
        cond = 4'hC;
        tick();
        expect_val("gt_cond_ex", S_CEX, 4'h0);
        check_out();
        cond = 4'hE;
        tick();
        expect_val("al2_cond_ex", S_CEX, 4'h1);
        check_out();
        cond = 4'hF;
        tick();
        idle();
        expect_val("nv_cond_ex", S_CEX, 4'h0);
        check_out();

        // stack fill, overflow, LIFO restore, underflow
        bank_sel = 1'b0;
        cond_valid = 1; cond = 4'hE;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            flag_w = 2'b11; alu_flags = vals[i];
            tick();
            idle();
            push = 1;
            tick();
            idle();
            expect_val($sformatf("push%0d_cnt", i), S_CNT, 4'(i + 1));
            expect_val($sformatf("push%0d_err", i), S_ERR, 4'h0);
            check_out();
        end
        push = 1;
        tick();
        idle();
        expect_val("overflow_err", S_ERR, 4'h1);
        expect_val("overflow_cnt", S_CNT, 4'h4);
        check_out();
        flag_w = 2'b11; alu_flags = 4'h0;
        tick();
        idle();
        for (int i = 3; i >= 0; i--) begin
            pop = 1; flag_w = 2'b11; alu_flags = 4'hF;
            tick();
            idle();
            expect_val($sformatf("pop%0d_flags", i), S_FLG, vals[i]);
            expect_val($sformatf("pop%0d_cnt", i), S_CNT, 4'(i));
            check_out();
        end
        pop = 1;
        tick();
        idle();
        expect_val("underflow_cnt", S_CNT, 4'h0);
        expect_val("underflow_err", S_ERR, 4'h1);
        check_out();

        do_reset();
        expect_val("err_cleared", S_ERR, 4'h0);
        check_out();
        pop = 1;
        tick();
        idle();
        expect_val("empty_pop_err", S_ERR, 4'h1);
        check_out();

        do_reset();
        push = 1; pop = 1;
        tick();
        idle();
        expect_val("push_pop_cnt", S_CNT, 4'h0);
        expect_val("push_pop_err", S_ERR, 4'h1);
        check_out();

        // reset asserted in the middle of a push plus flag write
        do_reset();
        push = 1;
        tick();
        idle();
        cond_valid = 1; cond = 4'hE;
        tick();
        idle();
        expect_val("pre_reset_cnt", S_CNT, 4'h1);
        expect_val("pre_reset_cond_ex", S_CEX, 4'h1);
        check_out();
        push = 1; flag_w = 2'b11; alu_flags = 4'hF; reg_w = 1; pcs = 1;
        #2;
        reset_n = 0;
        #1;
        expect_val("mid_rst_cond_ex", S_CEX, 4'h0);
        expect_val("mid_rst_flags", S_FLG, 4'h0);
        expect_val("mid_rst_cnt", S_CNT, 4'h0);
        expect_val("mid_rst_err", S_ERR, 4'h0);
        expect_val("mid_rst_reg_write", S_REGW, 4'h0);
        expect_val("mid_rst_pc_write", S_PCW, 4'h0);
        check_out();
        tick();
        expect_val("held_rst_flags", S_FLG, 4'h0);
        expect_val("held_rst_cnt", S_CNT, 4'h0);
        check_out();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
